// File: rtl/fir_audio_pkg.sv
// Shared definitions for the FIR to I2S transmit path.
// Frame geometry and transmitter state encoding.
package fir_audio_pkg;
   localparam int WD         = 24;
   localparam int FRAME_BITS = 64;
   localparam int SLOT_BITS  = 32;

   typedef enum logic {IDLE, RUN} tx_state_t;
endpackage

// File: rtl/audio_fifo.sv
// Small first-word-fall-through sample buffer.
// Pointers wrap naturally because the depth is a power of two.
module audio_fifo #(
   parameter int WD         = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WD-1:0]                 wdata,
   output logic [WD-1:0]                 rdata,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

   logic [WD-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/fir_i2s_tx.sv
// Mono I2S transmitter fed by the FIR stage.
// Each buffered sample is sent on both channels of one 64-bit frame.
module fir_i2s_tx #(
   parameter int WD         = fir_audio_pkg::WD,
   parameter int BCLK_DIV   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WD-1:0]                 in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          i2s_bclk,
   output logic                          i2s_lrck,
   output logic                          i2s_sdata,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   import fir_audio_pkg::*;

   localparam int DW = $clog2(BCLK_DIV + 1);
   localparam int BW = $clog2(FRAME_BITS);
   localparam int KW = $clog2(SLOT_BITS);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;
   logic [BW-1:0] bit_nxt;
   logic [KW-1:0] k_nxt;
   logic [WD-1:0] sample;
   logic [WD-1:0] shreg;
   logic [WD-1:0] rdata;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          div_wrap;
   logic          bclk_fall;
   logic          frame_wrap;

   assign in_ready = ~full & ~rst;
   assign push     = in_valid & in_ready;

   audio_fifo #(
      .WD         (WD),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      div_wrap   = 1'b0;
      bclk_fall  = 1'b0;
      frame_wrap = 1'b0;
      bit_nxt    = bit_cnt + 1'b1;
      k_nxt      = bit_nxt[KW-1:0];
      unique case (state)
         IDLE: begin
            if (!empty) begin
               state_nxt = RUN;
               pop       = 1'b1;
            end
         end
         RUN: begin
            div_wrap   = (div_cnt == DW'(BCLK_DIV - 1));
            bclk_fall  = div_wrap & i2s_bclk;
            frame_wrap = bclk_fall & (bit_cnt == BW'(FRAME_BITS - 1));
            pop        = frame_wrap & ~empty;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         sample    <= '0;
         shreg     <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
         underrun  <= 1'b0;
      end else if (state == IDLE) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
         underrun  <= 1'b0;
         if (pop) begin
            sample <= rdata;
            shreg  <= rdata;
         end
      end else begin
         underrun <= 1'b0;
         div_cnt  <= div_wrap ? '0 : div_cnt + 1'b1;
         if (div_wrap)
            i2s_bclk <= ~i2s_bclk;
         if (bclk_fall) begin
            bit_cnt  <= bit_nxt;
            i2s_lrck <= bit_nxt[BW-1];
            // Slot start: reload the word; data trails lrck by one bit.
            if (k_nxt == '0) begin
               i2s_sdata <= 1'b0;
               if (frame_wrap) begin
                  sample   <= pop ? rdata : '0;
                  shreg    <= pop ? rdata : '0;
                  underrun <= ~pop;
               end else begin
                  shreg <= sample;
               end
            end else if (int'(k_nxt) <= WD) begin
               i2s_sdata <= shreg[WD-1];
               shreg     <= shreg << 1;
            end else begin
               i2s_sdata <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_fir_i2s_tx.sv
// Bench for fir_i2s_tx: per-cycle frame-level reference model
// plus table-driven slot patterns and multi-cycle corner cases.
module tb_fir_i2s_tx;
   localparam int WDT = 24;
   localparam int BD  = 16;
   localparam int DEP = 4;
   localparam int LW  = 3;
   localparam int FR  = 64 * 2 * BD;

   logic           clk = 1'b0;
   logic           rst;
   logic [WDT-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   logic           i2s_bclk;
   logic           i2s_lrck;
   logic           i2s_sdata;
   logic           underrun;
   logic [LW-1:0]  fifo_level;

   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 0;

   logic [WDT-1:0] mq[$];
   bit             m_run = 0;
   bit             m_und = 0;
   int             m_t   = 0;
   logic [WDT-1:0] m_cur = '0;

   typedef struct {
      logic [WDT-1:0] smp;
      logic [31:0]    slot;
   } vec_t;

   vec_t tbl[6];

   fir_i2s_tx #(
      .WD         (WDT),
      .BCLK_DIV   (BD),
      .FIFO_DEPTH (DEP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .i2s_bclk   (i2s_bclk),
      .i2s_lrck   (i2s_lrck),
      .i2s_sdata  (i2s_sdata),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: time since RUN entry determines the bit position.
   task automatic model_step();
      bit acc;
      if (rst) begin
         mq.delete();
         m_run = 0;
         m_und = 0;
         m_t   = 0;
         m_cur = '0;
      end else begin
         acc = in_valid && (mq.size() < DEP);
         if (!m_run) begin
            if (mq.size() > 0) begin
               m_cur = mq.pop_front();
               m_run = 1;
               m_t   = 0;
               m_und = 0;
            end
         end else begin
            m_t++;
            if (m_t % FR == 0) begin
               if (mq.size() > 0) begin
                  m_cur = mq.pop_front();
                  m_und = 0;
               end else begin
                  m_cur = '0;
                  m_und = 1;
               end
            end
         end
         if (acc)
            mq.push_back(in_data);
      end
   endtask

   function automatic logic [7:0] model_out();
      logic ir, bc, lr, sd, un;
      int   bitc, k;
      ir = !rst && (mq.size() < DEP);
      bc = 0; lr = 0; sd = 0; un = 0;
      if (m_run) begin
         bc   = ((m_t / BD) % 2) == 1;
         bitc = (m_t / (2 * BD)) % 64;
         k    = bitc % 32;
         lr   = bitc >= 32;
         if (k >= 1 && k <= WDT)
            sd = m_cur[WDT-k];
         un = m_und && (m_t > 0) && (m_t % FR == 0);
      end
      return {ir, bc, lr, sd, un, LW'(mq.size())};
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (mon_en)
         check("cycle", {in_ready, i2s_bclk, i2s_lrck, i2s_sdata,
                         underrun, fifo_level}, model_out());
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++)
         step();
      rst = 1'b0;
   endtask

   task automatic push1(input logic [WDT-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic capture(output logic [63:0] sd, output logic [63:0] lr,
                          output bit ok);
      int   n;
      logic pb;
      n  = 0;
      pb = 1'b0;
      sd = '0;
      lr = '0;
      for (int c = 0; c < 3000 && n < 64; c++) begin
         @(negedge clk);
         if (i2s_bclk && !pb) begin
            sd = {sd[62:0], i2s_sdata};
            lr = {lr[62:0], i2s_lrck};
            n++;
         end
         pb = i2s_bclk;
      end
      ok = (n == 64);
      step();
   endtask

   initial begin
      logic [63:0] sd, lr;
      bit          ok;
      int          cnt;

      tbl[0] = '{24'hA50F3C, 32'h52879E00};
      tbl[1] = '{24'h800000, 32'h40000000};
      tbl[2] = '{24'h7FFFFF, 32'h3FFFFF80};
      tbl[3] = '{24'h000001, 32'h00000080};
      tbl[4] = '{24'hFFFFFF, 32'h7FFFFF80};
      tbl[5] = '{24'h000000, 32'h00000000};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      step();
      mon_en = 1;

      // Reset held for three cycles, then released.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_outputs", {in_ready, i2s_bclk, i2s_lrck, i2s_sdata,
                                 underrun, fifo_level}, 64'h0);
         step();
      end
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", in_ready, 1);
      step();

      // Slot patterns on both channels for each table sample.
      for (int v = 0; v < 6; v++) begin
         do_reset(2);
         push1(tbl[v].smp);
         capture(sd, lr, ok);
         check("capture_done", ok, 1);
         check("left_slot", sd[63:32], tbl[v].slot);
         check("right_slot", sd[31:0], tbl[v].slot);
         check("lrck_pattern", lr, {32'h0, 32'hFFFFFFFF});
         if (v == 0) begin
            cnt = 0;
            for (int c = 0; c < 1000; c++) begin
               @(negedge clk);
               if (underrun)
                  cnt++;
            end
            check("underrun_pulses", cnt, 1);
            step();
         end
      end

      // Back-pressure with in_valid held high from IDLE.
      do_reset(2);
      in_valid = 1'b1;
      in_data  = WDT'($urandom);
      cnt = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (in_ready)
            cnt++;
         step();
         in_data = WDT'($urandom);
      end
      check("accepted_count", cnt, 5);
      @(negedge clk);
      check("full_ready", in_ready, 0);
      check("full_level", fifo_level, 4);
      ok = 0;
      for (int c = 0; c < 3000 && !ok; c++) begin
         step();
         @(negedge clk);
         ok = in_ready;
      end
      check("ready_returns", ok, 1);
      check("level_after_pop", fifo_level, 3);
      step();
      in_valid = 1'b0;

      // Reset in the middle of a frame with two words buffered.
      do_reset(2);
      push1(WDT'($urandom));
      push1(WDT'($urandom));
      push1(WDT'($urandom));
      for (int c = 0; c < 3000 && !(m_run && m_t == 40 * 2 * BD + 3); c++)
         step();
      check("reach_bit40", m_t, 40 * 2 * BD + 3);
      check("level_mid_frame", fifo_level, 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("abort_outputs", {i2s_bclk, i2s_lrck, i2s_sdata, fifo_level}, 0);
      step();

      // Random traffic: sparse pushes, then starvation.
      do_reset(2);
      for (int c = 0; c < 10000; c++) begin
         in_valid = (c < 6000) && ($urandom_range(0, 999) < 2);
         in_data  = WDT'($urandom);
         step();
      end
      in_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fir_i2s_tx.md
FIR_I2S_TX -- requirements
Module: fir_i2s_tx

Interface
REQ-001 The block SHALL have parameter WD, default 24, meaning audio sample width in bits; it matches the FIR output width.
REQ-002 The block SHALL have parameter BCLK_DIV, default 16, meaning BCLK half-period in clk cycles: BCLK = 3.125 MHz at 100 MHz, fs about 48.8 kHz.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning input sample buffer depth in words; it is a power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, 100 MHz nominal; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data, input, WD bits: signed two's-complement sample from the FIR stage.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-009 The block SHALL have port i2s_bclk, output, 1 bit: serial bit clock.
REQ-010 The block SHALL have port i2s_lrck, output, 1 bit: word select; 0 = left channel, 1 = right channel.
REQ-011 The block SHALL have port i2s_sdata, output, 1 bit: serial data, MSB first.
REQ-012 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame starts with the FIFO empty.
REQ-013 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-014 A sample SHALL be written into the FIFO on each cycle where in_valid=1 and in_ready=1; in_ready SHALL equal !full, combinationally.
REQ-015 A write and a pop in the same cycle SHALL leave fifo_level unchanged; the FIFO read pointer and write pointer SHALL wrap modulo FIFO_DEPTH.
REQ-016 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-017 In IDLE, i2s_bclk, i2s_lrck and i2s_sdata SHALL be held at 0.
REQ-018 In IDLE with fifo_level≠0, the block SHALL in that cycle pop one sample into the shift register, move to RUN, and clear div_cnt and bit_cnt to 0.
REQ-019 In RUN, div_cnt SHALL count 0..BCLK_DIV-1, and i2s_bclk SHALL toggle on each wrap, so one BCLK period = 2*BCLK_DIV clk cycles.
REQ-020 A "BCLK fall" SHALL be defined as the cycle in which i2s_bclk goes from 1 to 0.
REQ-021 i2s_lrck and i2s_sdata SHALL change only on the BCLK fall.
REQ-022 bit_cnt (0..63) SHALL advance on each BCLK fall.
REQ-023 i2s_lrck SHALL be 0 for bit_cnt 0..31 and 1 for bit_cnt 32..63.
REQ-024 Within each channel slot, let k = bit_cnt mod 32; at k=1..WD, i2s_sdata SHALL carry sample bits WD-1 down to 0 (I2S one-bit delay); at k=0 and at k>WD, i2s_sdata SHALL be 0.
REQ-025 The same sample SHALL be sent on both the left and right channels (mono duplication).
REQ-026 At the BCLK fall where bit_cnt wraps from 63 to 0, the block SHALL pop the next sample; if the FIFO is empty, it SHALL load 0 and pulse underrun for exactly one cycle.
REQ-027 The block SHALL stay in RUN on underrun; i2s_lrck and i2s_bclk SHALL continue toggling without a gap.
REQ-028 Full frame length SHALL be 64*2*BCLK_DIV clk cycles, which is 2048 at the default parameter values.

Reset
REQ-029 While rst=1, at each clk edge the block SHALL enter IDLE, flush the FIFO (fifo_level=0), clear div_cnt, bit_cnt and the shift register, and drive i2s_bclk=0, i2s_lrck=0, i2s_sdata=0 and underrun=0.
REQ-030 in_ready SHALL be 0 while rst=1.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted in the middle of a frame SHALL abort the frame immediately, with no completion of the current word.

Structure
REQ-033 Shared package fir_audio_pkg SHALL hold: WD, FRAME_BITS=64, SLOT_BITS=32, and the FSM state enum (IDLE, RUN).
REQ-034 The FIFO SHALL be a separate sub-module, audio_fifo, with synchronous reset, push/pop/full/empty/level ports, and parameters WD and FIFO_DEPTH.
REQ-035 The FSM, BCLK divider and serializer SHALL reside in fir_i2s_tx.

Verification
REQ-036 Reset scenario: rst=1 for 3 cycles -> all outputs 0 and in_ready=0 during reset; in_ready=1 in the first cycle after release.
REQ-037 Single-sample scenario: push 24'hA50F3C -> on both channels, at k=1..24, i2s_sdata = 1010_0101_0000_1111_0011_1100; i2s_sdata=0 at k=0 and k=25..31; i2s_lrck high for 32 BCLKs.
REQ-038 Back-pressure scenario: hold in_valid=1 continuously from IDLE -> exactly 5 samples accepted (1 popped on RUN entry plus 4 stored), then in_ready=0; in_ready returns to 1 the cycle after the next frame-boundary pop.
REQ-039 Underrun scenario: push one sample, then nothing -> second frame sdata all 0, underrun=1 for exactly one cycle at its first BCLK fall, lrck toggles every 32 BCLKs.
REQ-040 Reset-mid-frame scenario: assert rst at bit_cnt=40 with fifo_level=2 -> next cycle bclk=lrck=sdata=0, fifo_level=0, state=IDLE.
REQ-041 Negative full-scale scenario: push 24'h800000 -> sdata=1 at k=1 only, 0 at k=2..31, on both channels.
